// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle for pipe_stage_reg: upstream payload and controls in,
// last-stage payload, occupancy and stall statistics out.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] Data_in;
    logic             Valid_in;
    logic             STALL;
    logic             FLUSH;
    logic             CLR_CNT;
    logic [WIDTH-1:0] Data_out;
    logic             Valid_out;
    logic [OCC_W-1:0] Occupancy;
    logic [CNT_W-1:0] Stall_cnt;

    // Hazard unit / upstream stage side.
    modport master (
        output Data_in, Valid_in, STALL, FLUSH, CLR_CNT,
        input  Data_out, Valid_out, Occupancy, Stall_cnt
    );

    // Pipeline register side.
    modport slave (
        input  Data_in, Valid_in, STALL, FLUSH, CLR_CNT,
        output Data_out, Valid_out, Occupancy, Stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Multi-stage pipeline register with per-stage valid, stall hold, flush-to-bubble,
// occupancy popcount and a saturating stalled-cycle counter.
module pipe_stage_reg #(
    parameter int               WIDTH            = 32,
    parameter int               DEPTH            = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE      = '0,
    parameter bit               NORMALIZE_BUBBLE = 1'b1,
    parameter int               CNT_W            = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    pipe_stage_reg_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [OCC_W-1:0] occ;
    logic [WIDTH-1:0] head_data;

    // Bubbles entering stage 0 are optionally rewritten to the nop encoding so
    // downstream decode never sees stale payload behind valid=0.
    generate
        if (NORMALIZE_BUBBLE) begin : g_norm
            assign head_data = bus.Valid_in ? bus.Data_in : RESET_VALUE;
        end else begin : g_raw
            assign head_data = bus.Data_in;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] up_data;
            logic             up_valid;

            if (gi == 0) begin : g_head
                assign up_data  = head_data;
                assign up_valid = bus.Valid_in;
            end else begin : g_body
                assign up_data  = data_q[gi-1];
                assign up_valid = valid_q[gi-1];
            end

            // FLUSH outranks STALL; a stalled stage never looks at its inputs.
            always_comb begin
                data_d[gi]  = data_q[gi];
                valid_d[gi] = valid_q[gi];
                if (bus.FLUSH) begin
                    data_d[gi]  = RESET_VALUE;
                    valid_d[gi] = 1'b0;
                end else if (!bus.STALL) begin
                    data_d[gi]  = up_data;
                    valid_d[gi] = up_valid;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    data_q[gi]  <= RESET_VALUE;
                    valid_q[gi] <= 1'b0;
                end else begin
                    data_q[gi]  <= data_d[gi];
                    valid_q[gi] <= valid_d[gi];
                end
            end
        end
    endgenerate

    // Counter clear wins over the increment; flush cycles are not counted as stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.CLR_CNT) begin
            cnt_d = '0;
        end else if (!bus.FLUSH && bus.STALL && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign bus.Data_out  = data_q[DEPTH-1];
    assign bus.Valid_out = valid_q[DEPTH-1];
    assign bus.Occupancy = occ;
    assign bus.Stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, latency, stall, flush, bubble
// normalisation and counter saturation across four parameterisations.
module tb_pipe_stage_reg;
    localparam logic [31:0] RV = 32'h5A5A_0013;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_pass;

    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) if3  ();
    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(1), .CNT_W(16)) if1n ();
    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(1), .CNT_W(16)) if1r ();
    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(2), .CNT_W(4))  if4  ();

    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(RV), .NORMALIZE_BUBBLE(1'b1), .CNT_W(16))
        u_d3 (.CLK(CLK), .RST_N(RST_N), .bus(if3.slave));
    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(RV), .NORMALIZE_BUBBLE(1'b1), .CNT_W(16))
        u_d1n (.CLK(CLK), .RST_N(RST_N), .bus(if1n.slave));
    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(RV), .NORMALIZE_BUBBLE(1'b0), .CNT_W(16))
        u_d1r (.CLK(CLK), .RST_N(RST_N), .bus(if1r.slave));
    pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(RV), .NORMALIZE_BUBBLE(1'b1), .CNT_W(4))
        u_c4 (.CLK(CLK), .RST_N(RST_N), .bus(if4.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-14s got 0x%0h", tag, obs);
        end else begin
            $display("FAIL %-14s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive the depth-3 instance and take one edge.
    task automatic push3(input logic v, input logic [31:0] d, input logic st, input logic fl);
        if3.Valid_in = v;
        if3.Data_in  = d;
        if3.STALL    = st;
        if3.FLUSH    = fl;
        step();
    endtask

    task automatic expect3(input string tag, input logic [31:0] d, input logic v, input int occ);
        check_eq({tag, ".data"}, 64'(if3.Data_out), 64'(d));
        check_eq({tag, ".valid"}, 64'(if3.Valid_out), 64'(v));
        check_eq({tag, ".occ"}, 64'(if3.Occupancy), 64'(occ));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST_N    = 1'b1;
        {if3.Valid_in, if3.STALL, if3.FLUSH, if3.CLR_CNT}     = '0;
        {if1n.Valid_in, if1n.STALL, if1n.FLUSH, if1n.CLR_CNT} = '0;
        {if1r.Valid_in, if1r.STALL, if1r.FLUSH, if1r.CLR_CNT} = '0;
        {if4.Valid_in, if4.STALL, if4.FLUSH, if4.CLR_CNT}     = '0;
        if3.Data_in  = 32'h0;
        if1n.Data_in = 32'h0;
        if1r.Data_in = 32'h0;
        if4.Data_in  = 32'h0;

        // Asynchronous reset between edges.
        #3 RST_N = 1'b0;
        #1;
        expect3("rst", RV, 1'b0, 0);
        check_eq("rst.cnt", 64'(if3.Stall_cnt), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;

        // Latency through three stages.
        push3(1'b1, 32'h11, 1'b0, 1'b0); expect3("lat1", RV, 1'b0, 1);
        push3(1'b1, 32'h22, 1'b0, 1'b0); expect3("lat2", RV, 1'b0, 2);
        push3(1'b1, 32'h33, 1'b0, 1'b0); expect3("lat3", 32'h11, 1'b1, 3);
        push3(1'b0, 32'h99, 1'b0, 1'b0); expect3("lat4", 32'h22, 1'b1, 2);
        push3(1'b0, 32'h98, 1'b0, 1'b0); expect3("lat5", 32'h33, 1'b1, 1);
        push3(1'b0, 32'h97, 1'b0, 1'b0); expect3("lat6", RV, 1'b0, 0);

        // Stall holds all stages while Data_in churns.
        push3(1'b1, 32'hA, 1'b0, 1'b0);
        push3(1'b1, 32'hB, 1'b0, 1'b0);
        push3(1'b1, 32'hC, 1'b0, 1'b0);
        expect3("load", 32'hA, 1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            push3(i[0], 32'hF00 + 32'(i), 1'b1, 1'b0);
            check_eq("stall.data", 64'(if3.Data_out), 64'hA);
        end
        expect3("stall", 32'hA, 1'b1, 3);
        check_eq("stall.cnt", 64'(if3.Stall_cnt), 64'd4);
        push3(1'b1, 32'hD, 1'b0, 1'b0); expect3("rel1", 32'hB, 1'b1, 3);
        push3(1'b1, 32'hE, 1'b0, 1'b0); expect3("rel2", 32'hC, 1'b1, 3);
        push3(1'b1, 32'hF, 1'b0, 1'b0); expect3("rel3", 32'hD, 1'b1, 3);

        // Flush outranks stall and does not count as a stall cycle.
        push3(1'b1, 32'h77, 1'b1, 1'b1);
        expect3("flush", RV, 1'b0, 0);
        check_eq("flush.cnt", 64'(if3.Stall_cnt), 64'd4);
        push3(1'b1, 32'h44, 1'b0, 1'b0); expect3("postfl", RV, 1'b0, 1);

        // Bubble normalisation on depth-1 instances.
        if1n.Valid_in = 1'b1; if1n.Data_in = 32'h1234_5678;
        if1r.Valid_in = 1'b1; if1r.Data_in = 32'h1234_5678;
        step();
        check_eq("nb1.v.data", 64'(if1n.Data_out), 64'h1234_5678);
        check_eq("nb1.v.occ", 64'(if1n.Occupancy), 64'd1);
        check_eq("nb0.v.valid", 64'(if1r.Valid_out), 64'd1);
        if1n.Valid_in = 1'b0; if1n.Data_in = 32'hDEAD_BEEF;
        if1r.Valid_in = 1'b0; if1r.Data_in = 32'hDEAD_BEEF;
        step();
        check_eq("nb1.data", 64'(if1n.Data_out), 64'(RV));
        check_eq("nb1.valid", 64'(if1n.Valid_out), 64'd0);
        check_eq("nb0.data", 64'(if1r.Data_out), 64'hDEAD_BEEF);
        check_eq("nb0.valid", 64'(if1r.Valid_out), 64'd0);
        check_eq("nb0.occ", 64'(if1r.Occupancy), 64'd0);

        // 4-bit counter saturation, clear priority, flush not counted.
        if4.STALL = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20)
                check_eq("sat.cnt", 64'(if4.Stall_cnt), 64'(i > 15 ? 15 : i));
        end
        if4.CLR_CNT = 1'b1;
        step();
        check_eq("clr.cnt", 64'(if4.Stall_cnt), 64'd0);
        if4.CLR_CNT = 1'b0;
        step();
        check_eq("restart.cnt", 64'(if4.Stall_cnt), 64'd1);
        if4.FLUSH = 1'b1;
        step();
        check_eq("flushsat.cnt", 64'(if4.Stall_cnt), 64'd1);
        if4.FLUSH = 1'b0;
        if4.STALL = 1'b0;

        // Reset asserted mid-stall acts immediately.
        push3(1'b1, 32'h55, 1'b0, 1'b0);
        push3(1'b1, 32'h56, 1'b0, 1'b0);
        push3(1'b1, 32'h57, 1'b1, 1'b0);
        check_eq("pre.cnt", 64'(if3.Stall_cnt), 64'd5);
        #2 RST_N = 1'b0;
        #1;
        expect3("midrst", RV, 1'b0, 0);
        check_eq("midrst.cnt", 64'(if3.Stall_cnt), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        push3(1'b1, 32'h66, 1'b0, 1'b0);
        expect3("afterrst", RV, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
